// File: rtl/dual_debounce_conditioner_pkg.sv
// Shared types and constants for the dual debounce conditioner.
package dual_debounce_conditioner_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    LOW_STABLE  = 2'd0,
    LOW_CHECK   = 2'd1,
    HIGH_STABLE = 2'd2,
    HIGH_CHECK  = 2'd3
  } db_state_e;

endpackage

// File: rtl/debounce_channel.sv
// One conditioner channel: 2-flop synchroniser, debounce FSM, rise pulse and
// stretched pulse.
//   state       | meaning
//   LOW_STABLE  | lvl=0, input agrees, cnt=0
//   LOW_CHECK   | lvl=0, input differs, counting toward acceptance
//   HIGH_STABLE | lvl=1, input agrees, cnt=0
//   HIGH_CHECK  | lvl=1, input differs, counting toward acceptance
module debounce_channel
  import dual_debounce_conditioner_pkg::*;
#(
  parameter int DB_CYCLES = 8,
  parameter int STRETCH   = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_in,
  output logic o_lvl,
  output logic o_rise,
  output logic o_bnc,
  output logic o_str
);

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] STRETCH_LD = CNT_W'(STRETCH);

  logic             r_sync1;
  logic             r_sync2;
  db_state_e        r_state;
  db_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] r_sc;
  logic [CNT_W-1:0] w_sc_nxt;
  logic             r_rise;
  logic             w_rise_nxt;
  logic             w_lvl;

  assign w_lvl = (r_state == HIGH_STABLE) || (r_state == HIGH_CHECK);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_state <= LOW_STABLE;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
      r_sc    <= '0;
    end else begin
      r_sync1 <= i_in;
      r_sync2 <= r_sync1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rise  <= w_rise_nxt;
      r_sc    <= w_sc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_rise_nxt  = 1'b0;
    w_sc_nxt    = (r_sc != '0) ? r_sc - CNT_W'(1) : r_sc;

    if (r_sync2 == w_lvl) begin
      w_state_nxt = w_lvl ? HIGH_STABLE : LOW_STABLE;
    end else if (r_cnt == CNT_LAST) begin
      w_state_nxt = w_lvl ? LOW_STABLE : HIGH_STABLE;
      // Only an accepted 0->1 pulses; a reload extends an active stretch.
      if (!w_lvl) begin
        w_rise_nxt = 1'b1;
        w_sc_nxt   = STRETCH_LD;
      end
    end else begin
      w_cnt_nxt   = r_cnt + CNT_W'(1);
      w_state_nxt = w_lvl ? HIGH_CHECK : LOW_CHECK;
    end
  end

  assign o_lvl  = w_lvl;
  assign o_rise = r_rise;
  assign o_bnc  = (r_sync2 != w_lvl);
  assign o_str  = (r_sc != '0);

endmodule

// File: rtl/dual_debounce_conditioner.sv
// 8-in/8-out tile: two independent debounce channels with optional input
// inversion, feeding the counter tile's clock-select inputs.
module dual_debounce_conditioner
  import dual_debounce_conditioner_pkg::*;
#(
  parameter int DB_CYCLES = 8,
  parameter int STRETCH   = 4
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  logic w_clk;
  logic w_rst;
  logic w_in_a;
  logic w_in_b;
  logic w_lvl_a, w_lvl_b;
  logic w_rise_a, w_rise_b;
  logic w_bnc_a, w_bnc_b;
  logic w_str_a, w_str_b;
  logic w_unused;

  assign w_clk    = io_in[0];
  assign w_rst    = io_in[1];
  assign w_in_a   = io_in[2] ^ io_in[4];
  assign w_in_b   = io_in[3] ^ io_in[4];
  assign w_unused = ^io_in[7:5];

  debounce_channel #(
    .DB_CYCLES (DB_CYCLES),
    .STRETCH   (STRETCH)
  ) u_chan_a (
    .i_clk  (w_clk),
    .i_rst  (w_rst),
    .i_in   (w_in_a),
    .o_lvl  (w_lvl_a),
    .o_rise (w_rise_a),
    .o_bnc  (w_bnc_a),
    .o_str  (w_str_a)
  );

  debounce_channel #(
    .DB_CYCLES (DB_CYCLES),
    .STRETCH   (STRETCH)
  ) u_chan_b (
    .i_clk  (w_clk),
    .i_rst  (w_rst),
    .i_in   (w_in_b),
    .o_lvl  (w_lvl_b),
    .o_rise (w_rise_b),
    .o_bnc  (w_bnc_b),
    .o_str  (w_str_b)
  );

  assign io_out = {w_str_b, w_str_a, w_bnc_b, w_bnc_a,
                   w_rise_b, w_rise_a, w_lvl_b, w_lvl_a};

endmodule

// File: tb/tb_dual_debounce_conditioner.sv
// Directed bench for dual_debounce_conditioner: default-parameter instance plus
// a fast-debounce instance used for the stretch-reload case.
module tb_dual_debounce_conditioner;

  logic       clk;
  logic       rst, raw_a, raw_b, inv;
  logic       rst_f, raw_f;
  logic [7:0] io_in, io_out;
  logic [7:0] io_in_f, io_out_f;
  int         checks;
  int         errors;
  logic [7:0] exp;

  assign io_in   = {3'b101, inv, raw_b, raw_a, rst, clk};
  assign io_in_f = {3'b000, 1'b0, 1'b0, raw_f, rst_f, clk};

  dual_debounce_conditioner dut (
    .io_in  (io_in),
    .io_out (io_out)
  );

  dual_debounce_conditioner #(
    .DB_CYCLES (2),
    .STRETCH   (4)
  ) dut_f (
    .io_in  (io_in_f),
    .io_out (io_out_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
    checks++;
    assert (got === want)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; raw_a = 1'b1; raw_b = 1'b0; inv = 1'b0;
    rst_f = 1'b1; raw_f = 1'b0;
    repeat (3) tick();
    check("reset_hold", io_out, 8'h00);
    check("reset_hold_f", io_out_f, 8'h00);

    // Held-high A through reset release: accepted on the 10th edge.
    rst = 1'b0; rst_f = 1'b0;
    for (int n = 1; n <= 14; n++) begin
      tick();
      if (n < 10)       exp = (n >= 2) ? 8'h10 : 8'h00;
      else if (n == 10) exp = 8'h45;
      else if (n <= 13) exp = 8'h41;
      else              exp = 8'h01;
      check($sformatf("rise_a_e%0d", n), io_out, exp);
    end

    // A falls: lvl drops 10 edges later with no pulse.
    raw_a = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      tick();
      exp = (n < 10) ? (8'h01 | ((n >= 2) ? 8'h10 : 8'h00)) : 8'h00;
      check($sformatf("fall_a_e%0d", n), io_out, exp);
    end

    // Five-sample glitch: bnc for 5 cycles, never accepted.
    for (int n = 1; n <= 12; n++) begin
      raw_a = (n <= 5);
      tick();
      exp = (n >= 2 && n <= 6) ? 8'h10 : 8'h00;
      check($sformatf("glitch_a_e%0d", n), io_out, exp);
    end

    // Inverted inputs: B low reads as high, A high reads as low.
    rst = 1'b1; inv = 1'b1; raw_a = 1'b1; raw_b = 1'b0;
    repeat (2) tick();
    check("reset_inv", io_out, 8'h00);
    rst = 1'b0;
    for (int n = 1; n <= 14; n++) begin
      tick();
      if (n < 10)       exp = (n >= 2) ? 8'h20 : 8'h00;
      else if (n == 10) exp = 8'h8A;
      else if (n <= 13) exp = 8'h82;
      else              exp = 8'h02;
      check($sformatf("inv_b_e%0d", n), io_out, exp);
    end

    // A starts counting; reset lands at cnt=5 and clears outputs at once.
    inv = 1'b0; raw_a = 1'b1; raw_b = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      tick();
      exp = (n >= 2) ? 8'h12 : 8'h02;
      check($sformatf("precount_e%0d", n), io_out, exp);
    end
    rst = 1'b1;
    #1;
    check("async_rst", io_out, 8'h00);
    repeat (2) tick();
    check("rst_held", io_out, 8'h00);
    rst = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      tick();
      exp = (n < 10) ? ((n >= 2) ? 8'h30 : 8'h00) : 8'hCF;
      check($sformatf("post_rst_e%0d", n), io_out, exp);
    end

    // Fast instance: rises 4 edges apart, stretch reloads without a gap.
    check("fast_idle", io_out_f, 8'h00);
    for (int n = 1; n <= 13; n++) begin
      raw_f = (n <= 2) || (n >= 5);
      tick();
      exp = {1'b0, (n >= 4 && n <= 11), 3'b000, (n == 4 || n == 8), 2'b00};
      check($sformatf("stretch_f_e%0d", n), io_out_f & 8'h44, exp);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
